// File: rtl/comparator_4_checker_pkg.sv
// ----------------------------------------------------------------------------
// comparator_4_checker_pkg
// Shared FSM encoding and default parameters for the comparator self-test.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package comparator_4_checker_pkg;

   localparam int DEFAULT_WIDTH  = 4;
   localparam int DEFAULT_SETTLE = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Reload value for a down-counting settle timer that expires at zero.
   function automatic logic [3:0] settle_load(input int settle_cycles);
      return 4'(settle_cycles - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_4_checker_sweep_counter.sv
// ----------------------------------------------------------------------------
// cmp_sweep_counter
// Vector index for the operand sweep: clear, increment and terminal flag.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmp_sweep_counter #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 last
);

   localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (inc) begin
         r_cnt <= r_cnt + c_one;
      end
   end

   assign cnt  = r_cnt;
   assign last = &r_cnt;

endmodule

`default_nettype wire

// File: rtl/comparator_4_checker.sv
// ----------------------------------------------------------------------------
// comparator_4_checker
// Sweeps every operand pair through an equality comparator and checks eq.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module comparator_4_checker
   import comparator_4_checker_pkg::*;
#(
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE   // legal range 1..15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               eq_in,
   output logic [WIDTH-1:0]   i0_out,
   output logic [WIDTH-1:0]   i1_out,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic               fail_valid,
   output logic [WIDTH-1:0]   fail_i0,
   output logic [WIDTH-1:0]   fail_i1
);

   localparam int VW = 2 * WIDTH;
   localparam int EW = 2 * WIDTH + 1;

   localparam logic [3:0]    c_settle_load = settle_load(SETTLE_CYCLES);
   localparam logic [EW-1:0] c_err_one     = EW'(1);

   state_t          r_state;
   state_t          w_next;
   logic [3:0]      r_settle;
   logic            w_clear;
   logic            w_inc;
   logic            w_last;
   logic [VW-1:0]   w_vec;
   logic            w_golden;
   logic            w_mismatch;
   logic [EW-1:0]   r_err;
   logic            r_fail_valid;
   logic [WIDTH-1:0] r_fail_i0;
   logic [WIDTH-1:0] r_fail_i1;

   cmp_sweep_counter #(
      .CNT_WIDTH (VW)
   ) u_sweep_counter (
      .clk   (clk),
      .rst   (rst),
      .clear (w_clear),
      .inc   (w_inc),
      .cnt   (w_vec),
      .last  (w_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_clear = 1'b0;
      w_inc   = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_clear = 1'b1;
               w_next  = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (r_settle == 4'd0) begin
               w_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (w_last) begin
               w_next = ST_DONE;
            end else begin
               w_inc  = 1'b1;
               w_next = ST_DRIVE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Reload on every DRIVE entry so each vector gets the full settle window.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_settle <= 4'd0;
      end else if (w_next == ST_DRIVE && r_state != ST_DRIVE) begin
         r_settle <= c_settle_load;
      end else if (r_state == ST_DRIVE && r_settle != 4'd0) begin
         r_settle <= r_settle - 4'd1;
      end
   end

   assign i0_out     = w_vec[VW-1:WIDTH];
   assign i1_out     = w_vec[WIDTH-1:0];
   assign w_golden   = (i0_out == i1_out);
   assign w_mismatch = (r_state == ST_CHECK) && (eq_in != w_golden);

   always_ff @(posedge clk) begin
      if (rst || w_clear) begin
         r_err <= '0;
      end else if (w_mismatch && r_err != {EW{1'b1}}) begin
         r_err <= r_err + c_err_one;
      end
   end

   // Only the first mismatch of a sweep is captured.
   always_ff @(posedge clk) begin
      if (rst || w_clear) begin
         r_fail_valid <= 1'b0;
         r_fail_i0    <= '0;
         r_fail_i1    <= '0;
      end else if (w_mismatch && !r_fail_valid) begin
         r_fail_valid <= 1'b1;
         r_fail_i0    <= i0_out;
         r_fail_i1    <= i1_out;
      end
   end

   assign busy       = (r_state == ST_DRIVE) || (r_state == ST_CHECK);
   assign done       = (r_state == ST_DONE);
   assign pass       = done && (r_err == '0);
   assign err_count  = r_err;
   assign fail_valid = r_fail_valid;
   assign fail_i0    = r_fail_i0;
   assign fail_i1    = r_fail_i1;

endmodule

`default_nettype wire

// File: tb/tb_comparator_4_checker.sv
// ----------------------------------------------------------------------------
// tb_comparator_4_checker
// Directed self-test scenarios with a fault-injectable comparator in the loop.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_comparator_4_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       eq_in;
   logic [3:0] i0_out;
   logic [3:0] i1_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [8:0] err_count;
   logic       fail_valid;
   logic [3:0] fail_i0;
   logic [3:0] fail_i1;

   int mode = 0;
   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   // 0 golden, 1 stuck-at-0, 2 inverted, 3 single fault at 15/13
   always_comb begin
      eq_in = (i0_out == i1_out);
      case (mode)
         1: eq_in = 1'b0;
         2: eq_in = (i0_out != i1_out);
         3: if (i0_out == 4'hF && i1_out == 4'hD) eq_in = 1'b1;
         default: ;
      endcase
   end

   comparator_4_checker #(
      .WIDTH         (4),
      .SETTLE_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .eq_in      (eq_in),
      .i0_out     (i0_out),
      .i1_out     (i1_out),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .fail_valid (fail_valid),
      .fail_i0    (fail_i0),
      .fail_i1    (fail_i1)
   );

   // Pulses start, then counts edges until done; optional extra start at pulse_at.
   task automatic run_sweep(input int pulse_at, output int cycles);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles = 0;
      while (done !== 1'b1 && cycles < 1000) begin
         if (cycles == pulse_at) start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vecs++;
      if ({busy, done, pass, fail_valid, err_count, fail_i0, fail_i1, i0_out, i1_out} !== 30'd0) begin
         errs++;
         $display("FAIL reset_outputs: got busy=%b done=%b pass=%b fv=%b err=%0d f=%0d/%0d op=%0d/%0d, want all 0",
                  busy, done, pass, fail_valid, err_count, fail_i0, fail_i1, i0_out, i1_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_golden();
      int cyc;
      mode = 0;
      while ($time < 90) @(negedge clk);
      run_sweep(-1, cyc);
      vecs++;
      if (cyc != 768) begin
         errs++;
         $display("FAIL golden_latency: got %0d cycles, want 768", cyc);
      end
      vecs++;
      if ({pass, busy, err_count, fail_valid} !== {1'b1, 1'b0, 9'd0, 1'b0}) begin
         errs++;
         $display("FAIL golden_result: got pass=%b busy=%b err=%0d fv=%b, want 1 0 0 0",
                  pass, busy, err_count, fail_valid);
      end
      vecs++;
      if ({i0_out, i1_out} !== 8'hFF) begin
         errs++;
         $display("FAIL golden_last_vector: got %0d/%0d, want 15/15", i0_out, i1_out);
      end
   endtask

   task automatic test_stuck_zero();
      int cyc;
      mode = 1;
      run_sweep(-1, cyc);
      vecs++;
      if ({done, pass, err_count, fail_valid, fail_i0, fail_i1} !== {1'b1, 1'b0, 9'd16, 1'b1, 4'd0, 4'd0}) begin
         errs++;
         $display("FAIL stuck_zero: got done=%b pass=%b err=%0d fv=%b first=%0d/%0d, want 1 0 16 1 0/0",
                  done, pass, err_count, fail_valid, fail_i0, fail_i1);
      end
   endtask

   task automatic test_inverted();
      int cyc;
      mode = 2;
      run_sweep(-1, cyc);
      vecs++;
      if ({done, pass, err_count, fail_valid, fail_i0, fail_i1} !== {1'b1, 1'b0, 9'd256, 1'b1, 4'd0, 4'd0}) begin
         errs++;
         $display("FAIL inverted: got done=%b pass=%b err=%0d fv=%b first=%0d/%0d, want 1 0 256 1 0/0",
                  done, pass, err_count, fail_valid, fail_i0, fail_i1);
      end
   endtask

   task automatic test_single_fault();
      int cyc;
      mode = 3;
      run_sweep(-1, cyc);
      vecs++;
      if ({done, pass, err_count, fail_valid, fail_i0, fail_i1} !== {1'b1, 1'b0, 9'd1, 1'b1, 4'd15, 4'd13}) begin
         errs++;
         $display("FAIL single_fault: got done=%b pass=%b err=%0d fv=%b first=%0d/%0d, want 1 0 1 1 15/13",
                  done, pass, err_count, fail_valid, fail_i0, fail_i1);
      end
   endtask

   task automatic test_start_while_busy();
      int cyc;
      mode = 0;
      run_sweep(50, cyc);
      vecs++;
      if (cyc != 768) begin
         errs++;
         $display("FAIL start_while_busy_latency: got %0d cycles, want 768", cyc);
      end
      vecs++;
      if ({pass, err_count, fail_valid} !== {1'b1, 9'd0, 1'b0}) begin
         errs++;
         $display("FAIL start_while_busy_result: got pass=%b err=%0d fv=%b, want 1 0 0",
                  pass, err_count, fail_valid);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int cyc;
      int idle_bad;
      mode = 2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (299) begin
         @(posedge clk);
         #1;
      end
      vecs++;
      if (busy !== 1'b1 || err_count == 9'd0) begin
         errs++;
         $display("FAIL mid_sweep_busy: got busy=%b err=%0d, want busy=1 err>0", busy, err_count);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      vecs++;
      if ({busy, done, pass, fail_valid, err_count, fail_i0, fail_i1, i0_out, i1_out} !== 30'd0) begin
         errs++;
         $display("FAIL mid_sweep_reset: got busy=%b done=%b pass=%b fv=%b err=%0d f=%0d/%0d op=%0d/%0d, want all 0",
                  busy, done, pass, fail_valid, err_count, fail_i0, fail_i1, i0_out, i1_out);
      end
      idle_bad = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || busy !== 1'b0) idle_bad++;
      end
      vecs++;
      if (idle_bad != 0) begin
         errs++;
         $display("FAIL mid_sweep_no_done: got %0d cycles with done/busy high after reset, want 0", idle_bad);
      end
      mode = 0;
      run_sweep(-1, cyc);
      vecs++;
      if (cyc != 768 || {pass, err_count, fail_valid} !== {1'b1, 9'd0, 1'b0}) begin
         errs++;
         $display("FAIL post_reset_sweep: got cycles=%0d pass=%b err=%0d fv=%b, want 768 1 0 0",
                  cyc, pass, err_count, fail_valid);
      end
   endtask

   initial begin
      test_reset();
      test_golden();
      test_stuck_zero();
      test_inverted();
      test_single_fault();
      test_start_while_busy();
      test_reset_mid_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

`default_nettype wire
